// File: rtl/handshake_pulse_arb.sv
// rtl/handshake_pulse_arb.sv - round-robin arbiter feeding one handshake pulse-sync channel
//
// Purpose: N_REQ requesters post single-cycle events; each is latched in a
// pending bit and issued one at a time as a one-cycle sync_pulse to a shared
// pulse-sync channel, which is then held busy for HOLD_CYC cycles. A
// sync_fail during the hold re-queues the event so it wins the next round.
//
// Ports:
//   src_clk     in   sole clock, rising edge
//   src_rst     in   asynchronous active-high reset
//   req_pulse   in   [N_REQ]  per-requester event request
//   sync_fail   in   channel sync-fail indication (honoured only in HOLD)
//   sync_pulse  out  one-cycle event to the channel source pulse input
//   sync_id     out  [IDW]    requester index of the in-flight event
//   req_done    out  [N_REQ]  one-cycle successful-delivery pulse
//   req_ovf     out  [N_REQ]  one-cycle lost-event pulse
//   busy        out  high in ISSUE and HOLD
module handshake_pulse_arb #(
  parameter  int N_REQ    = 4,
  parameter  int HOLD_CYC = 16,
  localparam int IDW      = $clog2(N_REQ)
) (
  input  logic             src_clk,
  input  logic             src_rst,
  input  logic [N_REQ-1:0] req_pulse,
  input  logic             sync_fail,
  output logic             sync_pulse,
  output logic [IDW-1:0]   sync_id,
  output logic [N_REQ-1:0] req_done,
  output logic [N_REQ-1:0] req_ovf,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] ovf_d;
  logic [IDW-1:0]   ptr_q;
  logic [7:0]       cnt_q;
  logic             fail_q;
  logic             sync_pulse_q;
  logic [IDW-1:0]   sync_id_q;
  logic [N_REQ-1:0] req_done_q;
  logic [N_REQ-1:0] req_ovf_q;
  logic             busy_q;

  logic [N_REQ-1:0] id_onehot;
  logic [N_REQ-1:0] issue_clr;
  logic [N_REQ-1:0] retry_set;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   id_next;
  logic [IDW:0]     scan_idx;
  logic             hold_fail;

  assign id_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sync_id_q;
  assign issue_clr = (state_q == S_ISSUE) ? id_onehot : '0;
  assign hold_fail = (state_q == S_HOLD) && sync_fail;
  assign retry_set = hold_fail ? id_onehot : '0;
  assign id_next   = (sync_id_q == IDW'(N_REQ - 1)) ? '0 : sync_id_q + 1'b1;

  // A request landing in the issue cycle of its own requester survives as a
  // new event (set wins over clear). A request that lands on a bit that is
  // still pending, or on a fail-retry re-set, is merged and reported as lost.
  always_comb begin
    pending_d = (pending_q & ~issue_clr) | req_pulse | retry_set;
    ovf_d     = req_pulse & ((pending_q & ~issue_clr) | retry_set);
  end

  // Scan from the pointer downwards in k so the smallest offset wins last.
  // scan_idx has one spare bit so ptr+k never overflows before the wrap.
  always_comb begin
    win_id   = '0;
    scan_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan_idx >= (IDW+1)'(N_REQ)) scan_idx = scan_idx - (IDW+1)'(N_REQ);
      if (pending_q[scan_idx[IDW-1:0]]) win_id = scan_idx[IDW-1:0];
    end
  end

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      fail_q       <= 1'b0;
      sync_pulse_q <= 1'b0;
      sync_id_q    <= '0;
      req_done_q   <= '0;
      req_ovf_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      req_ovf_q    <= ovf_d;
      sync_pulse_q <= 1'b0;
      req_done_q   <= '0;
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            sync_id_q    <= win_id;
            sync_pulse_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= 8'(HOLD_CYC - 1);
          fail_q  <= 1'b0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          if (sync_fail) fail_q <= 1'b1;
          if (cnt_q == 8'd0) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            // A fail in the final hold cycle still counts as a failure.
            if (fail_q || sync_fail) begin
              ptr_q <= sync_id_q;
            end else begin
              req_done_q <= id_onehot;
              ptr_q      <= id_next;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sync_pulse = sync_pulse_q;
  assign sync_id    = sync_id_q;
  assign req_done   = req_done_q;
  assign req_ovf    = req_ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_handshake_pulse_arb.sv
// tb/tb_handshake_pulse_arb.sv - directed-vector bench for handshake_pulse_arb
module tb_handshake_pulse_arb;

  localparam int NCYC = 80;

  logic       src_clk = 1'b0;
  logic       src_rst = 1'b1;
  logic [3:0] req_pulse = '0;
  logic       sync_fail = 1'b0;
  logic       sync_pulse;
  logic [1:0] sync_id;
  logic [3:0] req_done;
  logic [3:0] req_ovf;
  logic       busy;

  handshake_pulse_arb #(.N_REQ(4), .HOLD_CYC(16)) dut (
    .src_clk   (src_clk),
    .src_rst   (src_rst),
    .req_pulse (req_pulse),
    .sync_fail (sync_fail),
    .sync_pulse(sync_pulse),
    .sync_id   (sync_id),
    .req_done  (req_done),
    .req_ovf   (req_ovf),
    .busy      (busy)
  );

  always #5 src_clk = ~src_clk;

  int n_chk = 0;
  int n_err = 0;

  logic [3:0] req_s  [NCYC];
  logic       fail_s [NCYC];
  logic       sp_r   [NCYC];
  logic [1:0] id_r   [NCYC];
  logic [3:0] done_r [NCYC];
  logic [3:0] ovf_r  [NCYC];
  logic       busy_r [NCYC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_sched();
    for (int c = 0; c < NCYC; c++) begin
      req_s[c]  = '0;
      fail_s[c] = 1'b0;
    end
  endtask

  // Leaves the bench #1 after the edge that starts cycle 0.
  task automatic do_reset();
    src_rst   = 1'b1;
    req_pulse = '0;
    sync_fail = 1'b0;
    @(posedge src_clk);
    @(posedge src_clk);
    #1 src_rst = 1'b0;
  endtask

  task automatic run(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      req_pulse = req_s[c];
      sync_fail = fail_s[c];
      @(negedge src_clk);
      sp_r[c]   = sync_pulse;
      id_r[c]   = sync_id;
      done_r[c] = req_done;
      ovf_r[c]  = req_ovf;
      busy_r[c] = busy;
      @(posedge src_clk);
      #1;
    end
    req_pulse = '0;
    sync_fail = 1'b0;
  endtask

  function automatic int count_sp(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (sp_r[c]) n++;
    return n;
  endfunction

  function automatic int count_done(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (done_r[c] != 4'b0) n++;
    return n;
  endfunction

  function automatic int count_ovf(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (ovf_r[c] != 4'b0) n++;
    return n;
  endfunction

  function automatic int count_busy(input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++) if (busy_r[c]) n++;
    return n;
  endfunction

  initial begin
    // Reset state
    clear_sched();
    do_reset();
    src_rst = 1'b1;
    #1;
    chk("rst_sync_pulse", {31'b0, sync_pulse}, 32'd0);
    chk("rst_sync_id",    {30'b0, sync_id},    32'd0);
    chk("rst_req_done",   {28'b0, req_done},   32'd0);
    chk("rst_req_ovf",    {28'b0, req_ovf},    32'd0);
    chk("rst_busy",       {31'b0, busy},       32'd0);

    // Single event, with sync_fail pulses outside HOLD that must be ignored
    clear_sched();
    req_s[0] = 4'b0100;
    fail_s[1] = 1'b1;
    fail_s[2] = 1'b1;
    fail_s[19] = 1'b1;
    do_reset();
    run(40);
    chk("single_sp_c1",    {31'b0, sp_r[1]}, 32'd0);
    chk("single_sp_c2",    {31'b0, sp_r[2]}, 32'd1);
    chk("single_id_c2",    {30'b0, id_r[2]}, 32'd2);
    chk("single_sp_c3",    {31'b0, sp_r[3]}, 32'd0);
    chk("single_busy_c1",  {31'b0, busy_r[1]}, 32'd0);
    chk("single_busy_cnt", count_busy(2, 18), 32'd17);
    chk("single_busy_c19", {31'b0, busy_r[19]}, 32'd0);
    chk("single_done_c18", {28'b0, done_r[18]}, 32'd0);
    chk("single_done_c19", {28'b0, done_r[19]}, 32'h4);
    chk("single_id_c19",   {30'b0, id_r[19]}, 32'd2);
    chk("single_sp_total", count_sp(0, 39), 32'd1);
    chk("single_done_tot", count_done(0, 39), 32'd1);

    // Round-robin across all four requesters
    clear_sched();
    req_s[0] = 4'b1111;
    do_reset();
    run(78);
    chk("rr_sp_c2",   {31'b0, sp_r[2]},  32'd1);
    chk("rr_id_c2",   {30'b0, id_r[2]},  32'd0);
    chk("rr_sp_c20",  {31'b0, sp_r[20]}, 32'd1);
    chk("rr_id_c20",  {30'b0, id_r[20]}, 32'd1);
    chk("rr_sp_c38",  {31'b0, sp_r[38]}, 32'd1);
    chk("rr_id_c38",  {30'b0, id_r[38]}, 32'd2);
    chk("rr_sp_c56",  {31'b0, sp_r[56]}, 32'd1);
    chk("rr_id_c56",  {30'b0, id_r[56]}, 32'd3);
    chk("rr_sp_total", count_sp(0, 77), 32'd4);
    chk("rr_done_c19", {28'b0, done_r[19]}, 32'h1);
    chk("rr_done_c37", {28'b0, done_r[37]}, 32'h2);
    chk("rr_done_c55", {28'b0, done_r[55]}, 32'h4);
    chk("rr_done_c73", {28'b0, done_r[73]}, 32'h8);
    chk("rr_done_tot", count_done(0, 77), 32'd4);
    chk("rr_ovf_tot",  count_ovf(0, 77), 32'd0);

    // Fail and retry
    clear_sched();
    req_s[1] = 4'b0000;
    req_s[0] = 4'b0010;
    fail_s[3] = 1'b1;
    do_reset();
    run(45);
    chk("fail_sp_c2",    {31'b0, sp_r[2]},  32'd1);
    chk("fail_done_c19", {28'b0, done_r[19]}, 32'h0);
    chk("fail_sp_c20",   {31'b0, sp_r[20]}, 32'd1);
    chk("fail_id_c20",   {30'b0, id_r[20]}, 32'd1);
    chk("fail_done_c37", {28'b0, done_r[37]}, 32'h2);
    chk("fail_sp_total", count_sp(0, 44), 32'd2);
    chk("fail_done_tot", count_done(0, 44), 32'd1);

    // Overflow on a still-pending requester
    clear_sched();
    req_s[0] = 4'b0001;
    req_s[1] = 4'b0001;
    do_reset();
    run(45);
    chk("ovf_c1",       {28'b0, ovf_r[1]}, 32'h0);
    chk("ovf_c2",       {28'b0, ovf_r[2]}, 32'h1);
    chk("ovf_tot",      count_ovf(0, 44), 32'd1);
    chk("ovf_sp_total", count_sp(0, 44), 32'd1);
    chk("ovf_done_c19", {28'b0, done_r[19]}, 32'h1);

    // Request in its own ISSUE cycle is a fresh event
    clear_sched();
    req_s[0] = 4'b1000;
    req_s[2] = 4'b1000;
    do_reset();
    run(45);
    chk("coll_ovf_tot",  count_ovf(0, 44), 32'd0);
    chk("coll_sp_c20",   {31'b0, sp_r[20]}, 32'd1);
    chk("coll_id_c20",   {30'b0, id_r[20]}, 32'd3);
    chk("coll_sp_total", count_sp(0, 44), 32'd2);
    chk("coll_done_tot", count_done(0, 44), 32'd2);

    // Reset asserted mid-HOLD with another event pending
    clear_sched();
    req_s[0] = 4'b0001;
    req_s[1] = 4'b0010;
    do_reset();
    run(10);
    #3 src_rst = 1'b1;
    #1;
    chk("mid_rst_busy",  {31'b0, busy},       32'd0);
    chk("mid_rst_sp",    {31'b0, sync_pulse}, 32'd0);
    chk("mid_rst_id",    {30'b0, sync_id},    32'd0);
    chk("mid_rst_done",  {28'b0, req_done},   32'd0);
    chk("mid_rst_ovf",   {28'b0, req_ovf},    32'd0);
    clear_sched();
    do_reset();
    run(40);
    chk("post_rst_sp",   count_sp(0, 39), 32'd0);
    chk("post_rst_done", count_done(0, 39), 32'd0);
    chk("post_rst_busy", count_busy(0, 39), 32'd0);

    // Latency after an aborted hold follows the idle case
    clear_sched();
    req_s[0] = 4'b0001;
    do_reset();
    run(40);
    chk("lat_sp_c1",  {31'b0, sp_r[1]}, 32'd0);
    chk("lat_sp_c2",  {31'b0, sp_r[2]}, 32'd1);
    chk("lat_id_c2",  {30'b0, id_r[2]}, 32'd0);
    chk("lat_done_c19", {28'b0, done_r[19]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/handshake_pulse_arb.md
HANDSHAKE_PULSE_ARB -- requirements
Module: handshake_pulse_arb

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one handshake pulse-sync channel; legal range 2..8.
REQ-002 Parameter HOLD_CYC, default 16: src_clk cycles the channel is held busy after each issue; legal range 4..255.
REQ-003 src_clk  in  1  sole clock; all logic rising-edge.
REQ-004 src_rst  in  1  asynchronous, active-high reset.
REQ-005 req_pulse  in  N_REQ  per-requester single-cycle event request.
REQ-006 sync_fail  in  1  channel's one-cycle sync-fail indication.
REQ-007 sync_pulse  out  1  one-cycle event to the channel's source pulse input.
REQ-008 sync_id  out  ceil(log2(N_REQ))  requester index of the in-flight event.
REQ-009 req_done  out  N_REQ  one-cycle pulse per requester on successful delivery.
REQ-010 req_ovf  out  N_REQ  one-cycle pulse per requester when an event is lost.
REQ-011 busy  out  1  high in ISSUE and HOLD states.

Function
REQ-012 pending[N_REQ] register shall set on req_pulse[i] and clear only when requester i is issued.
REQ-013 FSM shall have states IDLE, ISSUE and HOLD.
REQ-014 IDLE: if pending nonzero, latch the round-robin winner (first set bit at or after pointer, wrapping N_REQ-1 to 0) into sync_id and go to ISSUE; else stay.
REQ-015 ISSUE: registered sync_pulse=1 for exactly this cycle; clear pending[sync_id]; load counter HOLD_CYC-1; clear fail flag; go to HOLD.
REQ-016 HOLD: decrement counter each cycle; at 0 go to IDLE, so HOLD lasts exactly HOLD_CYC cycles.
REQ-017 sync_fail high in any HOLD cycle shall set the fail flag and re-set pending[sync_id].
REQ-018 On HOLD exit with fail flag clear: req_done[sync_id]=1 in the first IDLE cycle; pointer = sync_id+1 (mod N_REQ).
REQ-019 On HOLD exit with fail flag set: no req_done; pointer = sync_id, so the retry wins next arbitration.
REQ-020 sync_fail outside HOLD shall be ignored.
REQ-021 Latency: req_pulse in cycle T with FSM idle and nothing pending -> sync_pulse in cycle T+2.
REQ-022 Minimum issue spacing: HOLD_CYC+2 cycles (ISSUE, HOLD_CYC, IDLE).
REQ-023 sync_id shall be stable from ISSUE through the IDLE cycle carrying req_done.
REQ-024 req_pulse[i] with pending[i] already set: req_ovf[i]=1 for one cycle next cycle; pending[i] stays set; one issue total.
REQ-025 req_pulse[i] in the ISSUE cycle of requester i: pending[i] remains set as a new event; no req_ovf.
REQ-026 req_pulse[i] coincident with a fail-retry re-set of pending[i]: pending[i] set; req_ovf[i]=1 (one event lost).
REQ-027 Multiple req_pulse bits in one cycle shall all be captured independently.

Reset
REQ-028 src_rst high shall immediately force: state IDLE, pending=0, pointer=0, counter=0, fail flag=0, sync_pulse=0, sync_id=0, req_done=0, req_ovf=0, busy=0.
REQ-029 Reset mid-ISSUE or mid-HOLD shall abort silently: no req_done, no retry; first event after release follows REQ-021.

Verification (N_REQ=4, HOLD_CYC=16, cycle 0 = first cycle after reset release)
REQ-030 Reset: assert src_rst with pending and FSM in HOLD -> all outputs 0 within the same cycle; no sync_pulse for 2 cycles after release.
REQ-031 Single event: req_pulse=4'b0100 at cycle 0 -> sync_pulse and sync_id=2 at cycle 2; busy cycles 2..18; req_done=4'b0100 at cycle 19.
REQ-032 Round-robin: req_pulse=4'b1111 at cycle 0 -> sync_pulse at cycles 2, 20, 38, 56 with sync_id 0, 1, 2, 3; four req_done pulses.
REQ-033 Fail retry: req_pulse=4'b0010 at cycle 0 and sync_fail at cycle 3 -> no req_done at cycle 19; sync_id=1 re-issued at cycle 20; req_done=4'b0010 at cycle 37.
REQ-034 Overflow: req_pulse[0] at cycles 0 and 1 -> req_ovf=4'b0001 at cycle 2; exactly one issue for requester 0.
REQ-035 Issue-cycle collision: req_pulse[3] at cycle 0 and again at cycle 2 (its ISSUE) -> no req_ovf; second issue of id 3 at cycle 20.
